// File: rtl/register_scoreboard.sv
// Issue-stage RAW hazard scoreboard: per-register pending-write counters for GPRs,
// FPRs and EFLAGS, decremented by writeback, with a saturating stall-cycle counter.

package register_scoreboard_pkg;
    localparam int NREG  = 16;
    localparam int IDX_W = $clog2(NREG);

    typedef struct packed {
        logic [IDX_W-1:0] d;
        logic [IDX_W-1:0] s;
        logic [IDX_W-1:0] t;
        logic             from_gd;
        logic             from_fd;
        logic             to_gd;
        logic             to_fd;
        logic             from_gs;
        logic             from_fs;
        logic             from_gt;
        logic             from_ft;
        logic             from_ef;
        logic             to_ef;
    } rut_t;
endpackage

module register_scoreboard
    import register_scoreboard_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  rut_t             rut,
    input  logic             ex_ready,
    output logic             in_ready,
    output logic             hazard,
    input  logic             wb_gd_valid,
    input  logic [IDX_W-1:0] wb_gd_idx,
    input  logic             wb_fd_valid,
    input  logic [IDX_W-1:0] wb_fd_idx,
    input  logic             wb_ef_valid,
    output logic             sb_err,
    output logic [31:0]      stall_cnt
);

    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_MAX = '1;

    cnt_t gcnt [NREG];
    cnt_t fcnt [NREG];
    cnt_t ecnt;

    logic src_busy;
    logic dst_full;
    logic underflow;
    logic issue;

    // Hazard looks only at registered counters: a writeback unblocks the next cycle.
    always_comb begin
        src_busy = (rut.from_gd && gcnt[rut.d] != '0)
                || (rut.from_fd && fcnt[rut.d] != '0)
                || (rut.from_gs && gcnt[rut.s] != '0)
                || (rut.from_fs && fcnt[rut.s] != '0)
                || (rut.from_gt && gcnt[rut.t] != '0)
                || (rut.from_ft && fcnt[rut.t] != '0)
                || (rut.from_ef && ecnt != '0);
        dst_full = (rut.to_gd && gcnt[rut.d] == CNT_MAX)
                || (rut.to_fd && fcnt[rut.d] == CNT_MAX)
                || (rut.to_ef && ecnt == CNT_MAX);
    end

    always_comb begin
        underflow = (wb_gd_valid && gcnt[wb_gd_idx] == '0)
                 || (wb_fd_valid && fcnt[wb_fd_idx] == '0)
                 || (wb_ef_valid && ecnt == '0);
    end

    assign hazard   = in_valid && (src_busy || dst_full);
    assign in_ready = ex_ready && !hazard;
    assign issue    = in_valid && in_ready;

    // A writeback to an idle counter floors at zero; the issue increment still applies.
    function automatic cnt_t next_cnt(input cnt_t c, input logic inc, input logic dec);
        return c + cnt_t'(inc) - cnt_t'(dec && c != '0);
    endfunction

    // NOTE: counters are individual flops, not a RAM, so every entry is reset explicitly.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                gcnt[i] <= '0;
                fcnt[i] <= '0;
            end
            ecnt      <= '0;
            sb_err    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (clear) begin
                for (int i = 0; i < NREG; i++) begin
                    gcnt[i] <= '0;
                    fcnt[i] <= '0;
                end
                ecnt   <= '0;
                sb_err <= 1'b0;
            end else begin
                for (int i = 0; i < NREG; i++) begin
                    gcnt[i] <= next_cnt(gcnt[i],
                                        issue && rut.to_gd && int'(rut.d) == i,
                                        wb_gd_valid && int'(wb_gd_idx) == i);
                    fcnt[i] <= next_cnt(fcnt[i],
                                        issue && rut.to_fd && int'(rut.d) == i,
                                        wb_fd_valid && int'(wb_fd_idx) == i);
                end
                ecnt <= next_cnt(ecnt, issue && rut.to_ef, wb_ef_valid);
                if (underflow) begin
                    sb_err <= 1'b1;
                end
            end
            if (in_valid && ex_ready && hazard && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed bench for register_scoreboard: a reference model pushes expected outputs into
// a queue as each cycle is driven; the entry is popped and compared at the falling edge.

module tb_register_scoreboard;
    import register_scoreboard_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             in_valid;
    rut_t             rut;
    logic             ex_ready;
    logic             in_ready;
    logic             hazard;
    logic             wb_gd_valid;
    logic [IDX_W-1:0] wb_gd_idx;
    logic             wb_fd_valid;
    logic [IDX_W-1:0] wb_fd_idx;
    logic             wb_ef_valid;
    logic             sb_err;
    logic [31:0]      stall_cnt;

    register_scoreboard #(.CNT_W(2)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .rut(rut),
        .ex_ready(ex_ready), .in_ready(in_ready), .hazard(hazard),
        .wb_gd_valid(wb_gd_valid), .wb_gd_idx(wb_gd_idx),
        .wb_fd_valid(wb_fd_valid), .wb_fd_idx(wb_fd_idx),
        .wb_ef_valid(wb_ef_valid), .sb_err(sb_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    localparam int MAXC = 3;

    typedef struct {
        string       tag;
        logic        hazard;
        logic        in_ready;
        logic        sb_err;
        logic [31:0] stall_cnt;
    } exp_t;

    exp_t q[$];
    int   gm [NREG];
    int   fm [NREG];
    int   em;
    bit   m_err;
    logic [31:0] m_stall;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_hazard();
        bit h;
        h = (rut.from_gd && gm[rut.d] != 0) || (rut.from_fd && fm[rut.d] != 0)
         || (rut.from_gs && gm[rut.s] != 0) || (rut.from_fs && fm[rut.s] != 0)
         || (rut.from_gt && gm[rut.t] != 0) || (rut.from_ft && fm[rut.t] != 0)
         || (rut.from_ef && em != 0)
         || (rut.to_gd && gm[rut.d] == MAXC) || (rut.to_fd && fm[rut.d] == MAXC)
         || (rut.to_ef && em == MAXC);
        return in_valid && h;
    endfunction

    function automatic int nxt(input int c, input bit inc, input bit dec);
        if (dec && c == 0) m_err = 1'b1;
        return c + int'(inc) - int'(dec && c > 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            gm[i] = 0;
            fm[i] = 0;
        end
        em    = 0;
        m_err = 1'b0;
    endtask

    task automatic model_edge();
        bit hz;
        bit iss;
        hz  = m_hazard();
        iss = in_valid && ex_ready && !hz;
        if (rst) begin
            model_reset();
            m_stall = '0;
        end else begin
            if (in_valid && ex_ready && hz && m_stall != '1) m_stall = m_stall + 1;
            if (clear) begin
                model_reset();
            end else begin
                for (int i = 0; i < NREG; i++) begin
                    gm[i] = nxt(gm[i], iss && rut.to_gd && int'(rut.d) == i,
                                wb_gd_valid && int'(wb_gd_idx) == i);
                    fm[i] = nxt(fm[i], iss && rut.to_fd && int'(rut.d) == i,
                                wb_fd_valid && int'(wb_fd_idx) == i);
                end
                em = nxt(em, iss && rut.to_ef, wb_ef_valid);
            end
        end
    endtask

    // want: 0/1 is a hand-derived hazard value for this step, 2 skips that extra check.
    task automatic cycle(input string tag, input int want);
        exp_t e;
        bit   hz;
        hz = m_hazard();
        e.tag       = tag;
        e.hazard    = hz;
        e.in_ready  = ex_ready && !hz;
        e.sb_err    = m_err;
        e.stall_cnt = m_stall;
        q.push_back(e);
        @(negedge clk);
        e = q.pop_front();
        check({e.tag, ".hazard"},   32'(hazard),   32'(e.hazard));
        check({e.tag, ".in_ready"}, 32'(in_ready), 32'(e.in_ready));
        check({e.tag, ".sb_err"},   32'(sb_err),   32'(e.sb_err));
        check({e.tag, ".stall"},    stall_cnt,     e.stall_cnt);
        if (want != 2) check({e.tag, ".want"}, 32'(hazard), want);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic v, input rut_t r, input logic exr);
        in_valid    = v;
        rut         = r;
        ex_ready    = exr;
        wb_gd_valid = 1'b0;
        wb_gd_idx   = '0;
        wb_fd_valid = 1'b0;
        wb_fd_idx   = '0;
        wb_ef_valid = 1'b0;
    endtask

    function automatic rut_t r_wg(input int d);
        rut_t r = '0;
        r.d = IDX_W'(d); r.to_gd = 1'b1;
        return r;
    endfunction

    function automatic rut_t r_rg(input int s);
        rut_t r = '0;
        r.s = IDX_W'(s); r.from_gs = 1'b1;
        return r;
    endfunction

    function automatic rut_t r_wf(input int d);
        rut_t r = '0;
        r.d = IDX_W'(d); r.to_fd = 1'b1;
        return r;
    endfunction

    function automatic rut_t r_rff(input int s);
        rut_t r = '0;
        r.s = IDX_W'(s); r.t = IDX_W'(s); r.from_fs = 1'b1; r.from_ft = 1'b1;
        return r;
    endfunction

    function automatic rut_t r_rmw(input int d);
        rut_t r = '0;
        r.d = IDX_W'(d); r.from_gd = 1'b1; r.to_gd = 1'b1;
        return r;
    endfunction

    function automatic rut_t r_cmp(input int s, input int t);
        rut_t r = '0;
        r.s = IDX_W'(s); r.t = IDX_W'(t); r.from_gs = 1'b1; r.from_gt = 1'b1; r.to_ef = 1'b1;
        return r;
    endfunction

    function automatic rut_t r_je();
        rut_t r = '0;
        r.from_ef = 1'b1;
        return r;
    endfunction

    initial begin
        rst   = 1'b1;
        clear = 1'b0;
        drive(1'b0, '0, 1'b1);
        model_reset();
        m_stall = '0;
        @(posedge clk);
        #1;
        cycle("rst_hold", 0);
        rst = 1'b0;
        cycle("idle", 0);

        // RAW on a GPR, released the cycle after writeback
        drive(1'b1, r_wg(3), 1'b1);  cycle("t1_add", 0);
        drive(1'b1, r_rg(3), 1'b1);  cycle("t1_stall_a", 1);
        cycle("t1_stall_b", 1);
        wb_gd_valid = 1'b1; wb_gd_idx = 4'd3;
        cycle("t1_wb_cycle", 1);
        drive(1'b1, r_rg(3), 1'b1);  cycle("t1_go", 0);

        // issue and writeback of the same GPR in one cycle
        drive(1'b1, r_wg(3), 1'b1);  cycle("t2_first", 0);
        drive(1'b1, r_wg(3), 1'b1);
        wb_gd_valid = 1'b1; wb_gd_idx = 4'd3;
        cycle("t2_same", 0);
        drive(1'b1, r_rg(3), 1'b1);  cycle("t2_rd", 1);
        wb_gd_valid = 1'b1; wb_gd_idx = 4'd3;
        cycle("t2_rd_wb", 1);
        drive(1'b1, r_rg(3), 1'b1);  cycle("t2_go", 0);

        // counter-full blocks the fourth in-flight write
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, r_wg(5), 1'b1);  cycle($sformatf("t3_w%0d", i), 0);
        end
        drive(1'b1, r_wg(5), 1'b1);  cycle("t3_full", 1);
        wb_gd_valid = 1'b1; wb_gd_idx = 4'd5;
        cycle("t3_full_wb", 1);
        drive(1'b1, r_wg(5), 1'b1);  cycle("t3_go", 0);
        drive(1'b1, '0, 1'b1);       cycle("t3_nop", 0);

        // d both read and written: only the pre-update value matters
        drive(1'b1, r_rmw(8), 1'b1); cycle("rmw_a", 0);
        drive(1'b1, r_rmw(8), 1'b1); cycle("rmw_b", 1);

        // FPR with duplicate sources s==t
        drive(1'b1, r_wf(4), 1'b1);  cycle("f_w", 0);
        drive(1'b1, r_rff(4), 1'b1); cycle("f_rd", 1);
        wb_fd_valid = 1'b1; wb_fd_idx = 4'd4;
        cycle("f_rd_wb", 1);
        drive(1'b1, r_rff(4), 1'b1); cycle("f_go", 0);

        // writeback underflow is sticky until clear
        drive(1'b0, '0, 1'b1);
        wb_fd_valid = 1'b1; wb_fd_idx = 4'd7;
        cycle("t4_wb0", 2);
        drive(1'b0, '0, 1'b1);       cycle("t4_err_a", 0);
        cycle("t4_err_b", 0);
        drive(1'b1, r_wg(6), 1'b1);
        clear = 1'b1;
        wb_gd_valid = 1'b1; wb_gd_idx = 4'd5;
        cycle("t4_clear", 0);
        clear = 1'b0;
        drive(1'b1, r_rg(5), 1'b1);  cycle("t4_rd5", 0);
        drive(1'b1, r_rg(6), 1'b1);  cycle("t4_rd6", 0);

        // CMP then JE: stalls counted only when ex_ready is high
        drive(1'b1, r_cmp(1, 2), 1'b1); cycle("t5_cmp", 0);
        drive(1'b1, r_je(), 1'b1);   cycle("t5_je_a", 1);
        drive(1'b1, r_je(), 1'b0);   cycle("t5_je_exr0", 1);
        drive(1'b1, r_je(), 1'b1);   cycle("t5_je_b", 1);
        wb_ef_valid = 1'b1;
        cycle("t5_je_wb", 1);
        drive(1'b1, r_je(), 1'b1);   cycle("t5_je_go", 0);
        drive(1'b0, '0, 1'b1);       cycle("t5_after", 0);

        // reset with counters nonzero and a live request
        drive(1'b1, r_wg(9), 1'b1);  cycle("t6_w9", 0);
        drive(1'b1, r_wf(2), 1'b1);  cycle("t6_wf2", 0);
        drive(1'b1, r_rg(9), 1'b1);
        rst = 1'b1;
        cycle("t6_rst", 1);
        rst = 1'b0;
        drive(1'b1, r_rg(9), 1'b1);  cycle("t6_after", 0);
        drive(1'b1, r_rff(2), 1'b0); cycle("t6_exr0", 0);
        drive(1'b0, '0, 1'b0);       cycle("t6_idle_exr0", 0);

        check("queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
